router_ctrl_fsm: RTL and testbench
==================================

Name:
router_ctrl_fsm

Overview:
Packet-sequencing controller for the 1x3 router. It decodes each packet header and steers header, payload and parity bytes into one of three 16x9 destination FIFOs. It stalls the source on FIFO full or busy, and tags the header write for the FIFO's length tracking. It also runs per-port read-timeout watchdogs that soft-reset a destination FIFO nobody drains.

Parameters:
TIMEOUT, 30, consecutive valid-but-unread cycles before a port's soft_reset pulses (min 2)
CW, 5, width of each timeout counter; must satisfy 2^CW >= TIMEOUT

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high; clears all state
pkt_valid  in  1  source byte valid; deasserts after last payload byte (parity byte follows)
low_pkt_valid  in  1  registered pkt_valid from source register (0 = parity byte pending)
parity_done  in  1  parity byte has been written
data_in  in  2  header address bits [1:0], meaningful in DECODE_ADDRESS only
fifo_full  in  3  full flag per FIFO
fifo_empty  in  3  empty flag per FIFO
read_enb  in  3  destination read enable per FIFO
busy  out  1  source must hold current byte
detect_add  out  1  header is being decoded (source register captures header)
lfd_state  out  1  header write cycle (FIFO bit 8 tag)
ld_state  out  1  payload load state
laf_state  out  1  load-after-full state
full_state  out  1  stalled on full FIFO
rst_int_reg  out  1  parity check cycle
write_enb  out  3  one-hot FIFO write enable
vld_out  out  3  ~fifo_empty, combinational
soft_reset  out  3  registered one-cycle FIFO flush pulse per port

Behaviour:
- State register is async-reset to DECODE_ADDRESS. Outputs are Moore-decoded from state, except write_enb and vld_out.
- addr_reg (2b) captures data_in on leaving DECODE_ADDRESS. selected full = fifo_full[addr_reg], selected sreset = soft_reset[addr_reg].
- write_enb = write_enb_reg ? (3'b001 << addr_reg) : 0. write_enb_reg=1 in LOAD_FIRST_DATA, LOAD_DATA, LOAD_AFTER_FULL, LOAD_PARITY.
- DECODE_ADDRESS: detect_add=1, busy=0. Transitions:
  - pkt_valid & data_in!=3 & fifo_empty[data_in] -> LOAD_FIRST_DATA
  - pkt_valid & data_in!=3 & !fifo_empty[data_in] -> WAIT_TILL_EMPTY
  - data_in==3 or !pkt_valid -> stay; invalid address is dropped with no write.
- WAIT_TILL_EMPTY: busy=1. -> LOAD_FIRST_DATA when fifo_empty[addr_reg].
- LOAD_FIRST_DATA: lfd_state=1, busy=1. Exactly one cycle -> LOAD_DATA.
- LOAD_DATA: ld_state=1, busy=0. Priority:
  - full -> FIFO_FULL_STATE
  - else !pkt_valid -> LOAD_PARITY
  - else stay.
- FIFO_FULL_STATE: full_state=1, busy=1, no write. -> LOAD_AFTER_FULL when !full.
- LOAD_AFTER_FULL: laf_state=1, busy=1. Priority:
  - parity_done -> DECODE_ADDRESS
  - else low_pkt_valid=0 -> LOAD_PARITY
  - else -> LOAD_DATA.
- LOAD_PARITY: busy=1. One cycle -> CHECK_PARITY_ERROR.
- CHECK_PARITY_ERROR: rst_int_reg=1, busy=1. full -> FIFO_FULL_STATE, else -> DECODE_ADDRESS.
- Soft reset: selected sreset=1 in any state except DECODE_ADDRESS -> DECODE_ADDRESS next edge. This overrides all other transitions. No write occurs in that cycle's successor.
- Watchdog, per port i:
  - cnt_i cleared when fifo_empty[i] | read_enb[i]; otherwise increments.
  - When cnt_i==TIMEOUT-1 and the port is still unread and non-empty: soft_reset[i]<=1 for one cycle and cnt_i<=0. Otherwise soft_reset[i]<=0.
  - Result: pulse appears after TIMEOUT consecutive unread cycles.
- Reset mid-packet: all outputs immediately return to reset values. Reset values: detect_add=1, every other output 0 except vld_out, soft_reset=0, counters=0.
- All three watchdogs run independently and concurrently with the FSM.

Test Plan:
- Reset, then pkt_valid=1, data_in=2'b01, fifo_empty=3'b111 -> edge 1 LOAD_FIRST_DATA (lfd_state=1, write_enb=3'b010, busy=1); edge 2 LOAD_DATA, busy=0.
- 4-byte payload, then pkt_valid=0 -> LOAD_PARITY for 1 cycle, CHECK_PARITY_ERROR with rst_int_reg=1, back to DECODE_ADDRESS; write_enb pulses cover header + 4 + parity = 6 cycles.
- fifo_full[0]=1 during LOAD_DATA at addr 0 -> FIFO_FULL_STATE, write_enb=0, busy=1. Release full with low_pkt_valid=1 -> LOAD_AFTER_FULL -> LOAD_DATA.
- data_in=2'b10, fifo_empty[2]=0 -> WAIT_TILL_EMPTY, busy=1. Assert fifo_empty[2]=1 -> LOAD_FIRST_DATA next edge. Separately, data_in=2'b11 -> stays DECODE_ADDRESS, write_enb=0.
- fifo_empty[1]=0, read_enb[1]=0 for 30 cycles -> soft_reset[1]=1 exactly one cycle after cycle 30. A read_enb[1] pulse at cycle 20 restarts the count.
- Packet in LOAD_DATA at addr 1 when soft_reset[1] pulses -> DECODE_ADDRESS next edge. Async reset asserted mid-LOAD_DATA -> detect_add=1 and write_enb=0 without waiting for a clock edge.

Source files
------------

// File: rtl/router_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// router_ctrl_fsm
//
// Packet sequencing controller for the 1x3 router. It decodes the header
// address, steers header, payload and parity bytes into one of three 16x9
// destination FIFOs, and holds the source off while a FIFO is full or still
// draining. A per-port read-timeout watchdog flushes any destination FIFO that
// holds data nobody reads.
//
// Source handshake: the source presents a byte and it is consumed on every
// rising edge where busy is low. While busy is high the source must hold the
// current byte unchanged. A FIFO accepts a byte on every edge where its
// write_enb bit is high.
//
// Ports
//   clock          system clock, all state on the rising edge
//   reset          asynchronous, active-high, clears all state
//   pkt_valid      source byte valid; drops after the last payload byte
//   low_pkt_valid  registered pkt_valid (0 = parity byte still pending)
//   parity_done    parity byte has been written
//   data_in        header address bits, used only while decoding
//   fifo_full      full flag per FIFO
//   fifo_empty     empty flag per FIFO
//   read_enb       read enable per FIFO (from the destinations)
//   busy           source must hold its current byte
//   detect_add     header is being decoded
//   lfd_state      header write cycle (tags FIFO bit 8)
//   ld_state       payload load state
//   laf_state      load-after-full state
//   full_state     stalled on a full FIFO
//   rst_int_reg    parity check cycle
//   write_enb      one-hot FIFO write enable
//   vld_out        data available per FIFO (~fifo_empty)
//   soft_reset     one-cycle flush pulse per FIFO
//   state          current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module router_ctrl_fsm #(
    // Consecutive non-empty, unread cycles before a port is flushed (>= 2).
    parameter int TIMEOUT = 30,
    // Counter width; 2**CW must be at least TIMEOUT.
    parameter int CW      = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       pkt_valid,
    input  logic       low_pkt_valid,
    input  logic       parity_done,
    input  logic [1:0] data_in,
    input  logic [2:0] fifo_full,
    input  logic [2:0] fifo_empty,
    input  logic [2:0] read_enb,
    output logic       busy,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic [2:0] write_enb,
    output logic [2:0] vld_out,
    output logic [2:0] soft_reset,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        WAIT_TILL_EMPTY    = 3'd1,
        LOAD_FIRST_DATA    = 3'd2,
        LOAD_DATA          = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_AFTER_FULL    = 3'd5,
        LOAD_PARITY        = 3'd6,
        CHECK_PARITY_ERROR = 3'd7
    } state_t;

    state_t          cur_state;
    state_t          next_state;
    logic [1:0]      addr_reg;
    logic            write_enb_reg;
    logic            sel_full;
    logic            sel_sreset;
    logic [2:0][CW-1:0] cnt;

    // Per-port flag select; address 3 never reaches addr_reg, but decode it
    // to 0 so a stray value can never select a write target.
    function automatic logic pick(input logic [2:0] v, input logic [1:0] a);
        case (a)
            2'd0:    pick = v[0];
            2'd1:    pick = v[1];
            2'd2:    pick = v[2];
            default: pick = 1'b0;
        endcase
    endfunction

    assign sel_full   = pick(fifo_full, addr_reg);
    assign sel_sreset = pick(soft_reset, addr_reg);
    assign write_enb  = write_enb_reg ? (3'b001 << addr_reg) : 3'b000;
    assign vld_out    = ~fifo_empty;
    assign state      = cur_state;

    // Next-state logic. A flush of the selected FIFO abandons the packet from
    // any state; that override wins over every normal transition.
    always_comb begin
        next_state = cur_state;
        if (cur_state != DECODE_ADDRESS && sel_sreset) begin
            next_state = DECODE_ADDRESS;
        end else begin
            case (cur_state)
                DECODE_ADDRESS: begin
                    // Address 3 has no destination: the header is dropped.
                    if (pkt_valid && data_in != 2'd3) begin
                        next_state = pick(fifo_empty, data_in) ? LOAD_FIRST_DATA
                                                               : WAIT_TILL_EMPTY;
                    end
                end
                WAIT_TILL_EMPTY: begin
                    if (pick(fifo_empty, addr_reg)) next_state = LOAD_FIRST_DATA;
                end
                LOAD_FIRST_DATA: next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (sel_full)        next_state = FIFO_FULL_STATE;
                    else if (!pkt_valid) next_state = LOAD_PARITY;
                end
                FIFO_FULL_STATE: begin
                    if (!sel_full) next_state = LOAD_AFTER_FULL;
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done)         next_state = DECODE_ADDRESS;
                    else if (!low_pkt_valid) next_state = LOAD_PARITY;
                    else                     next_state = LOAD_DATA;
                end
                LOAD_PARITY: next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    next_state = sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                default: next_state = DECODE_ADDRESS;
            endcase
        end
    end

    // State register plus Moore outputs, registered from the next state so
    // they line up with the state they describe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_state     <= DECODE_ADDRESS;
            addr_reg      <= 2'd0;
            busy          <= 1'b0;
            detect_add    <= 1'b1;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (cur_state == DECODE_ADDRESS && next_state != DECODE_ADDRESS) begin
                addr_reg <= data_in;
            end
            busy          <= 1'b0;
            detect_add    <= 1'b0;
            lfd_state     <= 1'b0;
            ld_state      <= 1'b0;
            laf_state     <= 1'b0;
            full_state    <= 1'b0;
            rst_int_reg   <= 1'b0;
            write_enb_reg <= 1'b0;
            case (next_state)
                DECODE_ADDRESS: detect_add <= 1'b1;
                WAIT_TILL_EMPTY: busy <= 1'b1;
                LOAD_FIRST_DATA: begin
                    lfd_state     <= 1'b1;
                    busy          <= 1'b1;
                    write_enb_reg <= 1'b1;
                end
                LOAD_DATA: begin
                    ld_state      <= 1'b1;
                    write_enb_reg <= 1'b1;
                end
                FIFO_FULL_STATE: begin
                    full_state <= 1'b1;
                    busy       <= 1'b1;
                end
                LOAD_AFTER_FULL: begin
                    laf_state     <= 1'b1;
                    busy          <= 1'b1;
                    write_enb_reg <= 1'b1;
                end
                LOAD_PARITY: begin
                    busy          <= 1'b1;
                    write_enb_reg <= 1'b1;
                end
                CHECK_PARITY_ERROR: begin
                    rst_int_reg <= 1'b1;
                    busy        <= 1'b1;
                end
                default: detect_add <= 1'b1;
            endcase
        end
    end

    // Read-timeout watchdogs. A counter restarts whenever its FIFO is empty or
    // being read; after TIMEOUT consecutive idle cycles the port gets a single
    // flush pulse and the count starts over.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            soft_reset <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (fifo_empty[i] || read_enb[i]) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b0;
                end else if (cnt[i] == CW'(TIMEOUT - 1)) begin
                    cnt[i]        <= '0;
                    soft_reset[i] <= 1'b1;
                end else begin
                    cnt[i]        <= cnt[i] + 1'b1;
                    soft_reset[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_router_ctrl_fsm
//
// Directed bench for router_ctrl_fsm. The driver pushes every expected FIFO
// write ({write_enb, lfd_state}) and every expected flush pulse into queues;
// a monitor on the falling edge pops and compares whenever the DUT drives a
// write or a soft_reset. Status outputs are compared directly after edges.
// -----------------------------------------------------------------------------
module tb_router_ctrl_fsm;

    logic       clock = 1'b0;
    logic       reset;
    logic       pkt_valid;
    logic       low_pkt_valid;
    logic       parity_done;
    logic [1:0] data_in;
    logic [2:0] fifo_full;
    logic [2:0] fifo_empty;
    logic [2:0] read_enb;
    logic       busy;
    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic [2:0] write_enb;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;
    logic [2:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    logic [3:0] exp_q[$];   // {write_enb, lfd_state} per expected write cycle
    logic [2:0] sr_q[$];    // expected soft_reset pulses
    logic [3:0] mon_w;
    logic [2:0] mon_s;

    // Expected status {busy, detect_add, lfd, ld, laf, full, rst_int_reg}
    localparam logic [6:0] S_DA  = 7'b0100000;
    localparam logic [6:0] S_WTE = 7'b1000000;
    localparam logic [6:0] S_LFD = 7'b1010000;
    localparam logic [6:0] S_LD  = 7'b0001000;
    localparam logic [6:0] S_FFS = 7'b1000010;
    localparam logic [6:0] S_LAF = 7'b1000100;
    localparam logic [6:0] S_LP  = 7'b1000000;
    localparam logic [6:0] S_CPE = 7'b1000001;

    router_ctrl_fsm #(.TIMEOUT(30), .CW(5)) dut (
        .clock        (clock),
        .reset        (reset),
        .pkt_valid    (pkt_valid),
        .low_pkt_valid(low_pkt_valid),
        .parity_done  (parity_done),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .read_enb     (read_enb),
        .busy         (busy),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .write_enb    (write_enb),
        .vld_out      (vld_out),
        .soft_reset   (soft_reset),
        .state        (state)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [6:0] st();
        st = {busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic exp_wr(input logic [2:0] we, input logic lfd);
        exp_q.push_back({we, lfd});
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (write_enb != 3'b000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {28'd0, write_enb, lfd_state}, 32'd0);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("write", {28'd0, write_enb, lfd_state}, {28'd0, mon_w});
                end
            end
            if (soft_reset != 3'b000) begin
                if (sr_q.size() == 0) begin
                    chk("unexpected_soft_reset", {29'd0, soft_reset}, 32'd0);
                end else begin
                    mon_s = sr_q.pop_front();
                    chk("soft_reset", {29'd0, soft_reset}, {29'd0, mon_s});
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; pkt_valid = 1'b0; low_pkt_valid = 1'b1; parity_done = 1'b0;
        data_in = 2'd0; fifo_full = 3'b000; fifo_empty = 3'b111; read_enb = 3'b000;
        step();
        chk("rst_status", st(), S_DA);
        chk("rst_write_enb", write_enb, 3'b000);
        chk("rst_soft_reset", soft_reset, 3'b000);
        chk("rst_vld_out", vld_out, 3'b000);
        reset = 1'b0;

        // Packet to port 1: header + 4 payload + parity = 6 writes
        pkt_valid = 1'b1; data_in = 2'd1;
        exp_wr(3'b010, 1'b1); step();
        chk("p1_lfd", st(), S_LFD);
        chk("p1_lfd_we", write_enb, 3'b010);
        exp_wr(3'b010, 1'b0); step();
        chk("p1_ld", st(), S_LD);
        for (int k = 0; k < 3; k++) begin
            exp_wr(3'b010, 1'b0); step();
        end
        pkt_valid = 1'b0; low_pkt_valid = 1'b0;
        exp_wr(3'b010, 1'b0); step();
        chk("p1_lp", st(), S_LP);
        step();
        chk("p1_cpe", st(), S_CPE);
        chk("p1_cpe_we", write_enb, 3'b000);
        step();
        chk("p1_da", st(), S_DA);

        // Port 0 stalls on full, resumes via LOAD_AFTER_FULL -> LOAD_DATA
        pkt_valid = 1'b1; low_pkt_valid = 1'b1; data_in = 2'd0;
        exp_wr(3'b001, 1'b1); step();
        exp_wr(3'b001, 1'b0); step();
        chk("f_ld", st(), S_LD);
        fifo_full = 3'b001; step();
        chk("f_ffs", st(), S_FFS);
        chk("f_ffs_we", write_enb, 3'b000);
        step();
        chk("f_ffs_hold", st(), S_FFS);
        fifo_full = 3'b000;
        exp_wr(3'b001, 1'b0); step();
        chk("f_laf", st(), S_LAF);
        exp_wr(3'b001, 1'b0); step();
        chk("f_laf_to_ld", st(), S_LD);
        pkt_valid = 1'b0; low_pkt_valid = 1'b0;
        exp_wr(3'b001, 1'b0); step();
        step(); step();
        chk("f_done_da", st(), S_DA);

        // LAF -> LOAD_PARITY, CPE on full -> FFS, LAF with parity_done -> DA
        pkt_valid = 1'b1; low_pkt_valid = 1'b1; data_in = 2'd0;
        exp_wr(3'b001, 1'b1); step();
        exp_wr(3'b001, 1'b0); step();
        fifo_full = 3'b001; step();
        chk("g_ffs", st(), S_FFS);
        fifo_full = 3'b000; pkt_valid = 1'b0; low_pkt_valid = 1'b0;
        exp_wr(3'b001, 1'b0); step();
        chk("g_laf", st(), S_LAF);
        exp_wr(3'b001, 1'b0); step();
        chk("g_laf_to_lp", st(), S_LP);
        fifo_full = 3'b001; step();
        chk("g_cpe", st(), S_CPE);
        step();
        chk("g_cpe_to_ffs", st(), S_FFS);
        fifo_full = 3'b000; parity_done = 1'b1;
        exp_wr(3'b001, 1'b0); step();
        chk("g_laf2", st(), S_LAF);
        step();
        chk("g_parity_done_da", st(), S_DA);
        parity_done = 1'b0;

        // Port 2 not empty -> WAIT_TILL_EMPTY until it drains
        pkt_valid = 1'b1; low_pkt_valid = 1'b1; data_in = 2'd2; fifo_empty = 3'b011;
        #1;
        chk("w_vld_out", vld_out, 3'b100);
        step();
        chk("w_wte", st(), S_WTE);
        chk("w_wte_we", write_enb, 3'b000);
        step();
        chk("w_wte_hold", st(), S_WTE);
        fifo_empty = 3'b111;
        exp_wr(3'b100, 1'b1); step();
        chk("w_lfd", st(), S_LFD);
        pkt_valid = 1'b0; low_pkt_valid = 1'b0;
        exp_wr(3'b100, 1'b0); step();
        exp_wr(3'b100, 1'b0); step();
        step(); step();
        chk("w_da", st(), S_DA);

        // Address 3 is dropped
        pkt_valid = 1'b1; data_in = 2'd3;
        step();
        chk("a3_da", st(), S_DA);
        step();
        chk("a3_da_hold", st(), S_DA);
        pkt_valid = 1'b0;

        // Watchdog on port 1: pulse after 30 unread cycles
        fifo_empty = 3'b101;
        for (int k = 1; k <= 30; k++) begin
            if (k == 30) sr_q.push_back(3'b010);
            step();
        end
        chk("wd_pulse", soft_reset, 3'b010);
        step();
        chk("wd_pulse_one_cycle", soft_reset, 3'b000);
        chk("wd_pulse_seen", sr_q.size(), 0);

        // A read at cycle 20 restarts the count: pulse moves to cycle 50
        fifo_empty = 3'b111; step();
        fifo_empty = 3'b101;
        for (int k = 1; k <= 50; k++) begin
            read_enb = (k == 20) ? 3'b010 : 3'b000;
            if (k == 50) sr_q.push_back(3'b010);
            step();
        end
        read_enb = 3'b000;
        chk("wd_restart_pulse", soft_reset, 3'b010);
        step();
        chk("wd_restart_seen", sr_q.size(), 0);

        // Flush of the selected port aborts a packet in LOAD_DATA
        fifo_empty = 3'b111; step();
        pkt_valid = 1'b1; low_pkt_valid = 1'b1; data_in = 2'd1;
        exp_wr(3'b010, 1'b1); step();
        exp_wr(3'b010, 1'b0); step();
        fifo_empty = 3'b101;
        for (int k = 1; k <= 30; k++) begin
            exp_wr(3'b010, 1'b0);
            if (k == 30) sr_q.push_back(3'b010);
            step();
        end
        chk("sr_pulse", soft_reset, 3'b010);
        chk("sr_still_ld", st(), S_LD);
        pkt_valid = 1'b0; low_pkt_valid = 1'b0;
        step();
        chk("sr_abort_da", st(), S_DA);
        chk("sr_abort_we", write_enb, 3'b000);
        fifo_empty = 3'b111; data_in = 2'd0;
        step();

        // Asynchronous reset in the middle of LOAD_DATA
        pkt_valid = 1'b1; low_pkt_valid = 1'b1; data_in = 2'd2;
        exp_wr(3'b100, 1'b1); step();
        exp_wr(3'b100, 1'b0); step();
        chk("ar_ld", st(), S_LD);
        #6;
        reset = 1'b1;
        #1;
        chk("ar_status", st(), S_DA);
        chk("ar_write_enb", write_enb, 3'b000);
        pkt_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("ar_after_da", st(), S_DA);

        chk("write_queue_drained", exp_q.size(), 0);
        chk("sr_queue_drained", sr_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
